spi_reg_access: RTL and testbench

//  Command sequencer directly upstream of the byte-level SPI driver (spi_driver).

---
 rtl/spi_reg_access.sv | 95 +++++++++
 tb/tb_spi_reg_access.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_access.sv
// spi_reg_access: turns one register-access command into a {rw,addr} header byte plus a data burst
// on the SPI byte driver's valid/ready port, returning read bytes on a registered pulse stream.
module spi_reg_access #(
   parameter int P_ADDR_WIDTH = 7,
   parameter int P_DATA_WIDTH = 8,
   parameter int P_LEN_WIDTH  = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic                    i_cmd_rw,
   input  logic [P_ADDR_WIDTH-1:0] i_cmd_addr,
   input  logic [P_LEN_WIDTH-1:0]  i_cmd_len,
   input  logic [P_DATA_WIDTH-1:0] i_wr_data,
   input  logic                    i_wr_valid,
   output logic                    o_wr_ready,
   output logic [P_DATA_WIDTH-1:0] o_rd_data,
   output logic                    o_rd_valid,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [P_DATA_WIDTH-1:0] o_drv_data,
   output logic                    o_drv_valid,
   input  logic                    i_drv_ready,
   input  logic [P_DATA_WIDTH-1:0] i_drv_rd_data,
   input  logic                    i_drv_rd_valid
);
   typedef enum logic [2:0] {S_IDLE, S_HDR, S_HDR_WAIT, S_DATA, S_DATA_WAIT, S_DONE} state_t;
   state_t                  state_q, state_d;
   logic                    rw_q, rw_d;
   logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [P_LEN_WIDTH-1:0]  len_q, len_d;
   logic [P_LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [P_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                    rd_valid_q, rd_valid_d;
   logic                    last;
   assign last = cnt_q == len_q;
   always_comb begin
      state_d    = state_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      case (state_q)
         S_IDLE: if (i_cmd_valid) begin
            state_d = S_HDR;
            rw_d    = i_cmd_rw;
            addr_d  = i_cmd_addr;
            len_d   = i_cmd_len;
            cnt_d   = '0;
         end
         S_HDR:      state_d = i_drv_ready ? S_HDR_WAIT : S_HDR;
         S_HDR_WAIT: state_d = i_drv_rd_valid ? S_DATA : S_HDR_WAIT;
         S_DATA:     state_d = (o_drv_valid && i_drv_ready) ? S_DATA_WAIT : S_DATA;
         S_DATA_WAIT: if (i_drv_rd_valid) begin
            rd_data_d  = rw_q ? i_drv_rd_data : rd_data_q;
            rd_valid_d = rw_q;
            state_d    = last ? S_DONE : S_DATA;
            cnt_d      = last ? cnt_q : cnt_q + 1'b1;
         end
         default:    state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end
   // write data passes straight through to the driver so a byte costs no extra cycle
   assign o_cmd_ready = state_q == S_IDLE;
   assign o_busy      = state_q != S_IDLE;
   assign o_done      = state_q == S_DONE;
   assign o_drv_valid = state_q == S_HDR || (state_q == S_DATA && (rw_q || i_wr_valid));
   assign o_drv_data  = state_q == S_HDR ? P_DATA_WIDTH'({rw_q, addr_q}) :
                        (state_q == S_DATA && !rw_q) ? i_wr_data : '0;
   assign o_wr_ready  = state_q == S_DATA && !rw_q && i_drv_ready;
   assign o_rd_data   = rd_data_q;
   assign o_rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_spi_reg_access.sv
// tb_spi_reg_access: random and directed command bursts against a byte-driver model, with
// expected driver bytes, read bytes and completions queued at issue and popped by a monitor.
module tb_spi_reg_access;
   typedef logic [7:0] bq_t[$];
   logic       i_clk = 1'b0, i_rst = 1'b0;
   logic       i_cmd_valid = 1'b0, i_cmd_rw = 1'b0;
   logic [6:0] i_cmd_addr = '0;
   logic [3:0] i_cmd_len = '0;
   logic [7:0] i_wr_data, i_drv_rd_data;
   logic       i_wr_valid, i_drv_ready, i_drv_rd_valid;
   logic       o_cmd_ready, o_wr_ready, o_rd_valid, o_busy, o_done, o_drv_valid;
   logic [7:0] o_rd_data, o_drv_data;

   spi_reg_access dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_rw(i_cmd_rw),
      .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
      .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
      .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_busy(o_busy), .o_done(o_done),
      .o_drv_data(o_drv_data), .o_drv_valid(o_drv_valid), .i_drv_ready(i_drv_ready),
      .i_drv_rd_data(i_drv_rd_data), .i_drv_rd_valid(i_drv_rd_valid)
   );

   always #5 i_clk = ~i_clk;

   int   checks = 0, errors = 0;
   bq_t  exp_drv_q, exp_rd_q, ret_q, wr_q;
   int   exp_done = 0, done_cnt = 0, rd_cnt = 0, acc_cnt = 0, acc_gap = 0;
   int   cyc = 0, last_done_cyc = 0, drv_hs_cnt = 0;
   int   stall_at = -1, stall_len = 0, wr_sent = 0;
   bit   stalling = 0, wr_pop = 0, drv_hs = 0, cur_rd = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: samples on the falling edge, away from the DUT's active edge
   always @(negedge i_clk) begin
      if (i_rst) begin
         drv_hs = 0;
         wr_pop = 0;
      end else begin
         cyc++;
         wr_pop = i_wr_valid && o_wr_ready;
         drv_hs = o_drv_valid && i_drv_ready;
         if (drv_hs) begin
            if (exp_drv_q.size() == 0) chk("drv_unexpected_byte", {24'h0, o_drv_data}, 32'hFFFF_FFFF);
            else chk("drv_byte", {24'h0, o_drv_data}, {24'h0, exp_drv_q.pop_front()});
         end
         if (o_rd_valid) begin
            rd_cnt++;
            if (exp_rd_q.size() == 0) chk("rd_unexpected_byte", {24'h0, o_rd_data}, 32'hFFFF_FFFF);
            else chk("rd_byte", {24'h0, o_rd_data}, {24'h0, exp_rd_q.pop_front()});
         end
         if (o_done) begin
            done_cnt++;
            last_done_cyc = cyc;
         end
         if (i_cmd_valid && o_cmd_ready) begin
            acc_cnt++;
            acc_gap = cyc - last_done_cyc;
            cur_rd  = i_cmd_rw;
         end
         if (cur_rd && o_busy) chk("wr_ready_during_read", {31'h0, o_wr_ready}, 0);
         if (stalling) begin
            chk("stall_drv_valid", {31'h0, o_drv_valid}, 0);
            chk("stall_busy", {31'h0, o_busy}, 1);
         end
      end
   end

   // byte-driver model: one byte in flight, read byte returned 1..4 cycles after acceptance
   initial begin
      bit pend;
      int wait_n;
      pend = 0;
      wait_n = 0;
      i_drv_ready = 1'b0;
      i_drv_rd_valid = 1'b0;
      i_drv_rd_data = '0;
      forever begin
         @(posedge i_clk);
         #1;
         i_drv_rd_valid = 1'b0;
         if (i_rst) begin
            pend = 0;
            i_drv_ready = 1'b0;
         end else if (drv_hs) begin
            drv_hs_cnt++;
            pend = 1;
            wait_n = $urandom_range(1, 4);
            i_drv_ready = 1'b0;
         end else if (pend) begin
            wait_n--;
            if (wait_n == 0) begin
               pend = 0;
               i_drv_rd_valid = 1'b1;
               i_drv_rd_data = ret_q.size() > 0 ? ret_q.pop_front() : 8'($urandom);
            end
         end else i_drv_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // write-data source: random gaps, plus an optional long stall before a chosen byte
   initial begin
      i_wr_valid = 1'b0;
      i_wr_data = '0;
      forever begin
         @(posedge i_clk);
         #1;
         if (wr_pop && wr_q.size() > 0) begin
            void'(wr_q.pop_front());
            wr_sent++;
         end
         stalling = wr_sent == stall_at && stall_len > 0 && wr_q.size() > 0;
         if (stalling) stall_len--;
         i_wr_valid = wr_q.size() > 0 && !stalling && ($urandom_range(0, 3) != 0);
         i_wr_data = wr_q.size() > 0 ? wr_q[0] : 8'($urandom);
      end
   end

   // reference: header {rw,addr}, then len+1 bytes (write data, or 00 dummies for reads)
   task automatic push_cmd(input bit rw, input logic [6:0] addr, input logic [3:0] len, input bq_t data);
      logic [7:0] b;
      exp_drv_q.push_back({rw, addr});
      ret_q.push_back(8'($urandom));
      for (int i = 0; i <= int'(len); i++) begin
         b = i < data.size() ? data[i] : 8'($urandom);
         if (rw) begin
            exp_drv_q.push_back(8'h00);
            ret_q.push_back(b);
            exp_rd_q.push_back(b);
         end else begin
            exp_drv_q.push_back(b);
            wr_q.push_back(b);
            ret_q.push_back(8'($urandom));
         end
      end
      exp_done++;
   endtask

   task automatic issue(input bit rw, input logic [6:0] addr, input logic [3:0] len, input bit hold);
      int n;
      n = 0;
      i_cmd_valid = 1'b1;
      i_cmd_rw = rw;
      i_cmd_addr = addr;
      i_cmd_len = len;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_cmd_ready && n < 3000);
      if (!o_cmd_ready) chk("cmd_accept_timeout", 0, 1);
      @(posedge i_clk);
      #1;
      if (!hold) begin
         i_cmd_valid = 1'b0;
         i_cmd_rw = 1'($urandom);
         i_cmd_addr = 7'($urandom);
         i_cmd_len = 4'($urandom);
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done_cnt < exp_done && n < 5000) begin
         @(negedge i_clk);
         n++;
      end
      repeat (3) @(negedge i_clk);
      chk({name, "_done_count"}, done_cnt, exp_done);
      chk({name, "_drv_bytes_left"}, exp_drv_q.size(), 0);
      chk({name, "_rd_bytes_left"}, exp_rd_q.size(), 0);
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_rd_data"}, {24'h0, o_rd_data}, 0);
      chk({name, "_rd_valid"}, {31'h0, o_rd_valid}, 0);
      chk({name, "_done"}, {31'h0, o_done}, 0);
      chk({name, "_busy"}, {31'h0, o_busy}, 0);
      chk({name, "_drv_valid"}, {31'h0, o_drv_valid}, 0);
      chk({name, "_wr_ready"}, {31'h0, o_wr_ready}, 0);
      chk({name, "_drv_data"}, {24'h0, o_drv_data}, 0);
      chk({name, "_cmd_ready"}, {31'h0, o_cmd_ready}, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t d;
      int base, n, rd0;
      bit rw;
      logic [3:0] len;
      #1 i_rst = 1'b1;
      #2 check_reset_outputs("reset");
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0;

      // write 0x12, two bytes
      d = {8'hA5, 8'h3C};
      rd0 = rd_cnt;
      push_cmd(1'b0, 7'h12, 4'd1, d);
      issue(1'b0, 7'h12, 4'd1, 1'b0);
      wait_done("t1_write");
      chk("t1_no_rd_valid", rd_cnt - rd0, 0);

      // read 0x05, three bytes
      d = {8'h11, 8'h22, 8'h33};
      rd0 = rd_cnt;
      push_cmd(1'b1, 7'h05, 4'd2, d);
      issue(1'b1, 7'h05, 4'd2, 1'b0);
      wait_done("t2_read");
      chk("t2_rd_pulses", rd_cnt - rd0, 3);

      // write with a 50-cycle underflow before the second data byte
      d.delete();
      wr_sent = 0;
      stall_at = 1;
      stall_len = 50;
      push_cmd(1'b0, 7'h2A, 4'd3, d);
      issue(1'b0, 7'h2A, 4'd3, 1'b0);
      wait_done("t3_stall");
      chk("t3_stall_consumed", stall_len, 0);
      stall_at = -1;

      // command held valid while busy: second one accepted the cycle after o_done
      base = acc_cnt;
      push_cmd(1'b1, 7'h33, 4'd1, d);
      push_cmd(1'b1, 7'h44, 4'd2, d);
      issue(1'b1, 7'h33, 4'd1, 1'b1);
      i_cmd_addr = 7'h44;
      i_cmd_len = 4'd2;
      n = 0;
      while (acc_cnt < base + 2 && n < 3000) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      i_cmd_valid = 1'b0;
      chk("t4_accepts", acc_cnt - base, 2);
      chk("t4_accept_after_done", acc_gap, 1);
      wait_done("t4_back_to_back");

      // reset during DATA_WAIT of a 4-byte read
      push_cmd(1'b1, 7'h5A, 4'd3, d);
      base = drv_hs_cnt;
      issue(1'b1, 7'h5A, 4'd3, 1'b0);
      n = 0;
      while (drv_hs_cnt < base + 3 && n < 3000) begin
         @(posedge i_clk);
         #2;
         n++;
      end
      chk("t5_reached_data_wait", drv_hs_cnt - base, 3);
      #1 i_rst = 1'b1;
      #2 check_reset_outputs("t5_midreset");
      exp_drv_q.delete();
      exp_rd_q.delete();
      ret_q.delete();
      wr_q.delete();
      exp_done = done_cnt;
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      d = {8'hC3, 8'h96};
      push_cmd(1'b0, 7'h07, 4'd1, d);
      issue(1'b0, 7'h07, 4'd1, 1'b0);
      wait_done("t5_after_reset");

      // longest burst
      rd0 = rd_cnt;
      d.delete();
      push_cmd(1'b1, 7'h7F, 4'd15, d);
      issue(1'b1, 7'h7F, 4'd15, 1'b0);
      wait_done("t6_len15");
      chk("t6_rd_pulses", rd_cnt - rd0, 16);

      // random commands
      for (int i = 0; i < 12; i++) begin
         rw = 1'($urandom);
         len = 4'($urandom);
         rd0 = rd_cnt;
         push_cmd(rw, 7'($urandom), len, d);
         issue(rw, exp_drv_q[0][6:0], len, 1'b0);
         wait_done("rand");
         chk("rand_rd_pulses", rd_cnt - rd0, rw ? int'(len) + 1 : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
